// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: entry layout, issue states, widths.
package lsq_pkg;

    localparam int LSQ_DEPTH  = 8;
    localparam int LSQ_IDX_W  = $clog2(LSQ_DEPTH);
    localparam int LSQ_ADDR_W = 32;
    localparam int LSQ_DATA_W = 32;
    localparam int LSQ_TAG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } lsq_state_e;

    // One queue slot; addr_ok and committed gate issue from the head.
    typedef struct packed {
        logic                  valid;
        logic                  is_store;
        logic [LSQ_TAG_W-1:0]  rob_tag;
        logic [LSQ_DATA_W-1:0] data;
        logic [LSQ_ADDR_W-1:0] addr;
        logic                  addr_ok;
        logic                  committed;
    } lsq_entry_t;

endpackage

// File: rtl/lsq_issue_fsm.sv
// Issue machine: launches the head entry to data memory and returns load data.
module lsq_issue_fsm
    import lsq_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  lsq_entry_t            i_head,
    input  logic                  i_flush,
    input  logic                  i_keep_head,
    input  logic                  i_mem_ack,
    input  logic [LSQ_DATA_W-1:0] i_mem_rdata,
    output logic                  o_deq,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [LSQ_ADDR_W-1:0] o_mem_addr,
    output logic [LSQ_DATA_W-1:0] o_mem_wdata,
    output logic                  o_ld_valid,
    output logic [LSQ_TAG_W-1:0]  o_ld_rob_tag,
    output logic [LSQ_DATA_W-1:0] o_ld_data
);

    lsq_state_e            r_state;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [LSQ_ADDR_W-1:0] r_mem_addr;
    logic [LSQ_DATA_W-1:0] r_mem_wdata;
    logic [LSQ_TAG_W-1:0]  r_tag;
    logic                  r_ld_valid;
    logic [LSQ_TAG_W-1:0]  r_ld_rob_tag;
    logic [LSQ_DATA_W-1:0] r_ld_data;

    logic w_kill;
    logic w_head_ready;

    // A flush aborts the access unless the head is a committed store.
    assign w_kill       = i_flush && !i_keep_head;
    assign w_head_ready = i_head.valid && i_head.addr_ok &&
                          (!i_head.is_store || i_head.committed);
    assign o_deq        = (r_state == REQ) && i_mem_ack && !w_kill;

    // Single state register plus registered memory and writeback outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_tag        <= '0;
            r_ld_valid   <= 1'b0;
            r_ld_rob_tag <= '0;
            r_ld_data    <= '0;
        end else begin
            r_ld_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_head_ready && !w_kill) begin
                        r_state     <= REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_head.is_store;
                        r_mem_addr  <= i_head.addr;
                        r_mem_wdata <= i_head.data;
                        r_tag       <= i_head.rob_tag;
                    end
                end
                REQ: begin
                    if (w_kill) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end else if (i_mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_ld_valid   <= 1'b1;
                            r_ld_rob_tag <= r_tag;
                            r_ld_data    <= i_mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_ld_valid   = r_ld_valid;
    assign o_ld_rob_tag = r_ld_rob_tag;
    assign o_ld_data    = r_ld_data;

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: circular entry buffer with head-only issue.
// The entry struct fixes field widths, so width parameters track lsq_pkg.
module load_store_queue
    import lsq_pkg::*;
#(
    parameter int DEPTH         = LSQ_DEPTH,
    parameter int ADDR_WIDTH    = LSQ_ADDR_W,
    parameter int DATA_WIDTH    = LSQ_DATA_W,
    parameter int ROB_TAG_WIDTH = LSQ_TAG_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic                     alloc_is_store_i,
    input  logic [ROB_TAG_WIDTH-1:0] alloc_rob_tag_i,
    input  logic [DATA_WIDTH-1:0]    alloc_data_i,
    output logic [$clog2(DEPTH)-1:0] alloc_idx_o,
    input  logic                     addr_valid_i,
    input  logic [$clog2(DEPTH)-1:0] addr_idx_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic                     commit_store_i,
    input  logic                     flush_i,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    output logic                     ld_valid_o,
    output logic [ROB_TAG_WIDTH-1:0] ld_rob_tag_o,
    output logic [DATA_WIDTH-1:0]    ld_data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    lsq_entry_t       r_entries [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    lsq_entry_t w_head;
    logic       w_alloc;
    logic       w_deq;
    logic       w_keep;
    logic       w_head_store;

    assign alloc_ready_o = rst_n_i && (r_count < CNT_W'(DEPTH));
    assign alloc_idx_o   = r_tail;
    assign w_alloc       = alloc_valid_i && alloc_ready_o;
    assign w_head        = r_entries[r_head];
    assign w_head_store  = w_head.valid && w_head.is_store;
    assign w_keep        = w_head_store && w_head.committed;

    // Entry array, pointers and occupancy; flush overrides alloc and address fill.
    // NOTE: only the valid bits are reset; payload fields are don't-care until
    // an allocation overwrites them, so they need no reset path.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!(w_keep && (IDX_W'(i) == r_head))) begin
                    r_entries[i].valid <= 1'b0;
                end
            end
            if (w_keep && w_deq) begin
                r_entries[r_head].valid <= 1'b0;
                r_head  <= r_head + 1'b1;
                r_tail  <= r_head + 1'b1;
                r_count <= '0;
            end else if (w_keep) begin
                r_tail  <= r_head + 1'b1;
                r_count <= CNT_W'(1);
            end else begin
                r_tail  <= r_head;
                r_count <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_entries[r_tail] <= '{valid:     1'b1,
                                       is_store:  alloc_is_store_i,
                                       rob_tag:   alloc_rob_tag_i,
                                       data:      alloc_data_i,
                                       addr:      '0,
                                       addr_ok:   1'b0,
                                       committed: 1'b0};
                r_tail <= r_tail + 1'b1;
            end
            if (addr_valid_i && r_entries[addr_idx_i].valid) begin
                r_entries[addr_idx_i].addr    <= addr_i;
                r_entries[addr_idx_i].addr_ok <= 1'b1;
            end
            if (commit_store_i && w_head_store) begin
                r_entries[r_head].committed <= 1'b1;
            end
            if (w_deq) begin
                r_entries[r_head].valid <= 1'b0;
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_deq);
        end
    end

    lsq_issue_fsm u_issue (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .i_head       (w_head),
        .i_flush      (flush_i),
        .i_keep_head  (w_keep),
        .i_mem_ack    (mem_ack_i),
        .i_mem_rdata  (mem_rdata_i),
        .o_deq        (w_deq),
        .o_mem_req    (mem_req_o),
        .o_mem_we     (mem_we_o),
        .o_mem_addr   (mem_addr_o),
        .o_mem_wdata  (mem_wdata_o),
        .o_ld_valid   (ld_valid_o),
        .o_ld_rob_tag (ld_rob_tag_o),
        .o_ld_data    (ld_data_o)
    );

    // An address must target a live entry; a commit must find a store at head.
    a_addr_live: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (addr_valid_i && !flush_i) |-> r_entries[addr_idx_i].valid);
    a_commit_store: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        commit_store_i |-> w_head_store);

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue with hand-computed expectations.
module tb_load_store_queue;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic        alloc_ready_o;
    logic        alloc_is_store_i = 1'b0;
    logic [4:0]  alloc_rob_tag_i = '0;
    logic [31:0] alloc_data_i = '0;
    logic [2:0]  alloc_idx_o;
    logic        addr_valid_i = 1'b0;
    logic [2:0]  addr_idx_i = '0;
    logic [31:0] addr_i = '0;
    logic        commit_store_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        ld_valid_o;
    logic [4:0]  ld_rob_tag_o;
    logic [31:0] ld_data_o;

    int n_vec  = 0;
    int n_miss = 0;

    load_store_queue dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .alloc_valid_i    (alloc_valid_i),
        .alloc_ready_o    (alloc_ready_o),
        .alloc_is_store_i (alloc_is_store_i),
        .alloc_rob_tag_i  (alloc_rob_tag_i),
        .alloc_data_i     (alloc_data_i),
        .alloc_idx_o      (alloc_idx_o),
        .addr_valid_i     (addr_valid_i),
        .addr_idx_i       (addr_idx_i),
        .addr_i           (addr_i),
        .commit_store_i   (commit_store_i),
        .flush_i          (flush_i),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .ld_valid_o       (ld_valid_o),
        .ld_rob_tag_o     (ld_rob_tag_o),
        .ld_data_o        (ld_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        step();
        step();
        rst_n_i = 1'b1;
        step();
    endtask

    task automatic do_alloc(input logic st, input logic [4:0] tag, input logic [31:0] data);
        alloc_valid_i    = 1'b1;
        alloc_is_store_i = st;
        alloc_rob_tag_i  = tag;
        alloc_data_i     = data;
        step();
        alloc_valid_i    = 1'b0;
    endtask

    task automatic give_addr(input logic [2:0] idx, input logic [31:0] a);
        addr_valid_i = 1'b1;
        addr_idx_i   = idx;
        addr_i       = a;
        step();
        addr_valid_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req_o && n < 30) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 64'(!mem_req_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;

        // Reset values
        step();
        check("rst_ready", alloc_ready_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_ldv", ld_valid_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_lddata", ld_data_o, 0);
        rst_n_i = 1'b1;
        step();
        check("post_rst_ready", alloc_ready_o, 1);
        check("post_rst_idx", alloc_idx_o, 0);

        // Load: alloc at N-1, address at N, request at N+2, writeback at N+3
        do_alloc(1'b0, 5'd3, 32'h0);
        give_addr(3'd0, 32'h100);
        check("ld_lat_n1_req", mem_req_o, 0);
        step();
        check("ld_lat_n2_req", mem_req_o, 1);
        check("ld_we", mem_we_o, 0);
        check("ld_addr", mem_addr_o, 32'h100);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEADBEEF;
        step();
        mem_ack_i = 1'b0;
        check("ld_valid", ld_valid_o, 1);
        check("ld_tag", ld_rob_tag_o, 3);
        check("ld_data", ld_data_o, 32'hDEADBEEF);
        check("ld_req_drop", mem_req_o, 0);
        step();
        check("ld_pulse_1cyc", ld_valid_o, 0);

        // Store waits for commit
        check("st_idx", alloc_idx_o, 1);
        do_alloc(1'b1, 5'd7, 32'h55);
        give_addr(3'd1, 32'h200);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req_o) seen = 1'b1;
            step();
        end
        check("st_no_req_uncommitted", seen, 0);
        commit_store_i = 1'b1;
        step();
        commit_store_i = 1'b0;
        check("st_commit_c1_req", mem_req_o, 0);
        step();
        check("st_req", mem_req_o, 1);
        check("st_we", mem_we_o, 1);
        check("st_addr", mem_addr_o, 32'h200);
        check("st_wdata", mem_wdata_o, 32'h55);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check("st_no_ldv", ld_valid_o, 0);
        check("st_req_drop", mem_req_o, 0);
        step();
        check("st_no_ldv2", ld_valid_o, 0);

        // Full queue refuses allocation even during a dequeue
        do_reset();
        alloc_valid_i = 1'b1;
        alloc_is_store_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            alloc_rob_tag_i = 5'(8 + i);
            check($sformatf("fill_idx%0d", i), alloc_idx_o, 64'(i));
            step();
        end
        check("full_ready", alloc_ready_o, 0);
        check("full_tail", alloc_idx_o, 0);
        addr_valid_i = 1'b1;
        addr_idx_i   = 3'd0;
        addr_i       = 32'h300;
        step();
        addr_valid_i = 1'b0;
        step();
        check("full_req", mem_req_o, 1);
        check("full_ready_in_req", alloc_ready_o, 0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hA5A5_0000;
        step();
        mem_ack_i = 1'b0;
        check("deq_ready", alloc_ready_o, 1);
        check("deq_tail_wrap", alloc_idx_o, 0);
        check("deq_ld_tag", ld_rob_tag_o, 8);
        step();
        alloc_valid_i = 1'b0;
        check("refill_tail", alloc_idx_o, 1);
        check("refill_ready", alloc_ready_o, 0);

        // Out-of-order addresses still issue in program order
        do_reset();
        do_alloc(1'b0, 5'd1, 32'h0);
        do_alloc(1'b0, 5'd2, 32'h0);
        do_alloc(1'b0, 5'd3, 32'h0);
        give_addr(3'd2, 32'h2C0);
        give_addr(3'd1, 32'h1C0);
        give_addr(3'd0, 32'h0C0);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_addr;
            exp_addr = 32'h0C0 + 32'(k) * 32'h100;
            wait_req($sformatf("ooo%0d", k));
            check($sformatf("ooo_addr%0d", k), mem_addr_o, 64'(exp_addr));
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'(k + 16);
            step();
            mem_ack_i = 1'b0;
            check($sformatf("ooo_tag%0d", k), ld_rob_tag_o, 64'(k + 1));
            check($sformatf("ooo_data%0d", k), ld_data_o, 64'(k + 16));
            check($sformatf("ooo_gap%0d", k), mem_req_o, 0);
        end

        // Flush keeps a committed store in flight, drops the younger load
        do_reset();
        do_alloc(1'b1, 5'd4, 32'hAA);
        do_alloc(1'b0, 5'd5, 32'h0);
        give_addr(3'd0, 32'h400);
        give_addr(3'd1, 32'h500);
        commit_store_i = 1'b1;
        step();
        commit_store_i = 1'b0;
        wait_req("fl_st");
        check("fl_st_we", mem_we_o, 1);
        check("fl_st_addr", mem_addr_o, 32'h400);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("fl_st_held", mem_req_o, 1);
        check("fl_tail", alloc_idx_o, 1);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check("fl_st_done", mem_req_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req_o || ld_valid_o) seen = 1'b1;
            step();
        end
        check("fl_ld_never", seen, 0);
        check("fl_count", dut.r_count, 0);

        // Reset during an outstanding request
        do_reset();
        do_alloc(1'b0, 5'd6, 32'h0);
        give_addr(3'd0, 32'h600);
        wait_req("rr_first");
        rst_n_i = 1'b0;
        step();
        check("rr_req_low", mem_req_o, 0);
        check("rr_ready_low", alloc_ready_o, 0);
        rst_n_i = 1'b1;
        step();
        check("rr_ready", alloc_ready_o, 1);
        check("rr_idx", alloc_idx_o, 0);
        do_alloc(1'b0, 5'd9, 32'h0);
        give_addr(3'd0, 32'h700);
        wait_req("rr_next");
        check("rr_addr", mem_addr_o, 32'h700);
        check("rr_we", mem_we_o, 0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h12345678;
        step();
        mem_ack_i = 1'b0;
        check("rr_ldv", ld_valid_o, 1);
        check("rr_tag", ld_rob_tag_o, 9);
        check("rr_data", ld_data_o, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
